// File: rtl/row_fetch_ctrl_pkg.sv
// Shared constants, FSM state type and address helper for the row fetch path.
package row_fetch_ctrl_pkg;

  localparam int WORDS_PER_ROW  = 80;
  localparam int BURST_LEN      = 8;
  localparam int ROWS           = 480;
  localparam int ADDR_W         = 24;
  localparam int FRAME_BASE     = 0;
  localparam int DATA_W         = 128;
  localparam int IDX_W          = 9;

  localparam int BURSTS_PER_ROW = WORDS_PER_ROW / BURST_LEN;
  localparam int BEAT_W         = $clog2(BURST_LEN);
  localparam int BURST_W        = $clog2(BURSTS_PER_ROW);
  localparam int WORD_W         = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Word address of the first word of a row; constant multiply folds to shift-add.
  function automatic logic [ADDR_W-1:0] row_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(FRAME_BASE) + ADDR_W'(idx) * ADDR_W'(WORDS_PER_ROW);
  endfunction

endpackage

// File: rtl/row_fetch_ctrl.sv
// Row fetch controller: reads one display row from memory in fixed bursts and
// writes each returned word into the ping-pong row buffer.
//
// Handshakes: mem_rd_req is held with a stable mem_rd_addr until the cycle in
// which mem_rd_req and mem_rd_ack are both 1 (transfer accepted); it drops the
// following cycle. mem_rd_valid has no back-pressure: every beat seen in DATA is
// written one cycle later, beats seen in REQ/DONE are dropped and flag err.
module row_fetch_ctrl
  import row_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [IDX_W-1:0]  line_idx,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              buf_wr_en,
  output logic [WORD_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              buf_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output state_t            dbg_state
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [BURST_W-1:0]  r_burst_cnt;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [WORD_W-1:0]   r_word_cnt;
  logic                r_req;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_buf_sel;
  logic                r_wr_en;
  logic [WORD_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic                w_idx_ok;
  logic                w_last_beat;
  logic                w_last_burst;
  logic                w_req_bad;
  logic                w_valid_bad;

  assign w_idx_ok     = (line_idx < IDX_W'(ROWS));
  assign w_last_beat  = (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign w_last_burst = (r_burst_cnt == BURST_W'(BURSTS_PER_ROW - 1));
  // A request while busy (including the DONE cycle) or for a non-existent row.
  assign w_req_bad    = line_req && ((r_state != ST_IDLE) || !w_idx_ok);
  // Data with no open burst; IDLE is exempt so stray beats after a reset are quiet.
  assign w_valid_bad  = mem_rd_valid && ((r_state == ST_REQ) || (r_state == ST_DONE));

  // Fetch FSM with address generation, write pipeline and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_burst_cnt <= '0;
      r_beat_cnt  <= '0;
      r_word_cnt  <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_buf_sel   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (w_req_bad || w_valid_bad) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (line_req && w_idx_ok) begin
            r_addr      <= row_base(line_idx);
            r_burst_cnt <= '0;
            r_beat_cnt  <= '0;
            r_word_cnt  <= '0;
            r_req       <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_rd_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_rd_valid) begin
            r_wr_en    <= 1'b1;
            r_wr_addr  <= r_word_cnt;
            r_wr_data  <= mem_rd_data;
            r_word_cnt <= r_word_cnt + WORD_W'(1);
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              if (w_last_burst) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                r_addr      <= r_addr + ADDR_W'(BURST_LEN);
                r_req       <= 1'b1;
                r_state     <= ST_REQ;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_buf_sel <= ~r_buf_sel;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_req  = r_req;
  assign mem_rd_addr = r_addr;
  assign buf_wr_en   = r_wr_en;
  assign buf_wr_addr = r_wr_addr;
  assign buf_wr_data = r_wr_data;
  assign buf_sel     = r_buf_sel;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule
